// File: rtl/branch_resolve_unit.sv
// LEGv8 branch resolution: decodes B/BL/B.cond/CBZ/BR, owns NZCV,
// and squashes wrong-path instructions after a taken branch.
module branch_resolve_unit #(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        pc_stall,
  input  logic        flags_we,
  input  logic [3:0]  flags_in,
  input  logic        reg_zero,
  output logic        ctrl_valid,
  output logic        UncondBr,
  output logic        BrTaken,
  output logic        BranchToReg,
  output logic [25:0] BrAddr26,
  output logic [18:0] CondAddr19,
  output logic        is_link,
  output logic [3:0]  flags
);

  localparam logic [2:0] FD = 3'(FLUSH_DEPTH);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t     state;
  logic [2:0] squash_cnt;

  logic is_b, is_bl, is_cbz, is_bcond, is_br;
  logic [3:0] eff;
  logic n, z, c, v;
  logic base, cond_ok;

  logic        nx_ub, nx_bt, nx_btr, nx_link;
  logic [25:0] nx_a26;
  logic [18:0] nx_a19;

  assign in_ready = !pc_stall;

  assign is_b     = instr[31:26] == 6'b000101;
  assign is_bl    = instr[31:26] == 6'b100101;
  assign is_cbz   = instr[31:24] == 8'b10110100;
  assign is_bcond = instr[31:24] == 8'b01010100;
  assign is_br    = instr[31:21] == 11'b11010110000;

  // zero-cycle forwarding of an ALU flag write
  assign eff = flags_we ? flags_in : flags;
  assign {n, z, c, v} = eff;

  always_comb begin
    base = 1'b1;
    case (instr[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & !z;
      3'd5:    base = n == v;
      3'd6:    base = !z & (n == v);
      default: base = 1'b1;
    endcase
    // odd codes invert, except AL/NV which are always true
    cond_ok = (instr[3:1] == 3'b111) ? 1'b1 : (base ^ instr[0]);
  end

  always_comb begin
    nx_ub   = 1'b0;
    nx_bt   = 1'b0;
    nx_btr  = 1'b0;
    nx_link = 1'b0;
    nx_a26  = '0;
    nx_a19  = '0;
    unique case (1'b1)
      is_b, is_bl: begin
        nx_ub   = 1'b1;
        nx_bt   = 1'b1;
        nx_a26  = instr[25:0];
        nx_link = is_bl;
      end
      is_bcond: begin
        nx_bt  = cond_ok;
        nx_a19 = instr[23:5];
      end
      is_cbz: begin
        nx_bt  = reg_zero;
        nx_a19 = instr[23:5];
      end
      is_br: begin
        nx_bt  = 1'b1;
        nx_btr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      squash_cnt  <= '0;
      flags       <= '0;
      ctrl_valid  <= 1'b0;
      UncondBr    <= 1'b0;
      BrTaken     <= 1'b0;
      BranchToReg <= 1'b0;
      BrAddr26    <= '0;
      CondAddr19  <= '0;
      is_link     <= 1'b0;
    end else begin
      if (flags_we)
        flags <= flags_in;
      if (!pc_stall) begin
        ctrl_valid  <= 1'b0;
        UncondBr    <= 1'b0;
        BrTaken     <= 1'b0;
        BranchToReg <= 1'b0;
        BrAddr26    <= '0;
        CondAddr19  <= '0;
        is_link     <= 1'b0;
        if (in_valid) begin
          if (state == SQUASH) begin
            squash_cnt <= squash_cnt - 3'd1;
            if (squash_cnt == 3'd1)
              state <= RUN;
          end else begin
            ctrl_valid  <= 1'b1;
            UncondBr    <= nx_ub;
            BrTaken     <= nx_bt;
            BranchToReg <= nx_btr;
            BrAddr26    <= nx_a26;
            CondAddr19  <= nx_a19;
            is_link     <= nx_link;
            if (nx_bt) begin
              squash_cnt <= FD;
              if (FD != 3'd0)
                state <= SQUASH;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized scoreboard bench for branch_resolve_unit against a
// counter-based reference model of the squash and condition rules.
module tb_branch_resolve_unit;

  localparam int FD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        pc_stall;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic        reg_zero;
  logic        ctrl_valid;
  logic        UncondBr;
  logic        BrTaken;
  logic        BranchToReg;
  logic [25:0] BrAddr26;
  logic [18:0] CondAddr19;
  logic        is_link;
  logic [3:0]  flags;

  branch_resolve_unit #(.FLUSH_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_stall(pc_stall), .flags_we(flags_we),
    .flags_in(flags_in), .reg_zero(reg_zero),
    .ctrl_valid(ctrl_valid), .UncondBr(UncondBr),
    .BrTaken(BrTaken), .BranchToReg(BranchToReg),
    .BrAddr26(BrAddr26), .CondAddr19(CondAddr19),
    .is_link(is_link), .flags(flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {UncondBr, BrTaken, BranchToReg, BrAddr26, CondAddr19, is_link}
  logic [48:0] expq[$];
  logic [3:0]  m_flags;
  int          m_cnt;

  function automatic bit cond_holds(logic [3:0] cd, logic [3:0] f);
    bit fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cd)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !(fc && !fz);
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return !(!fz && (fn == fv));
      default: return 1'b1;
    endcase
  endfunction

  // Predicts the effect of the coming clock edge from current inputs.
  task automatic model();
    logic [3:0] eff;
    bit ub, bt, btr, lk;
    logic [25:0] a26;
    logic [18:0] a19;
    if (!reset) begin
      m_cnt = 0;
      m_flags = 4'h0;
      return;
    end
    eff = flags_we ? flags_in : m_flags;
    if (flags_we) m_flags = flags_in;
    if (pc_stall || !in_valid) return;
    if (m_cnt > 0) begin
      m_cnt--;
      return;
    end
    ub = 0; bt = 0; btr = 0; lk = 0; a26 = '0; a19 = '0;
    if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
      ub = 1; bt = 1; a26 = instr[25:0];
      lk = instr[31];
    end else if (instr[31:24] == 8'hB4) begin
      bt = reg_zero; a19 = instr[23:5];
    end else if (instr[31:24] == 8'h54) begin
      bt = cond_holds(instr[3:0], eff); a19 = instr[23:5];
    end else if (instr[31:21] == 11'b11010110000) begin
      bt = 1; btr = 1;
    end
    expq.push_back({ub, bt, btr, a26, a19, lk});
    if (bt) m_cnt = FD;
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    checks++;
    if (flags !== m_flags) begin
      errors++;
      $display("FAIL flags: got %h want %h", flags, m_flags);
    end
    checks++;
    if (in_ready !== !pc_stall) begin
      errors++;
      $display("FAIL in_ready: got %b want %b", in_ready, !pc_stall);
    end
  endtask

  task automatic drive(logic r, logic v, logic [31:0] w, logic st,
                       logic fwe, logic [3:0] fi, logic rz);
    reset = r; in_valid = v; instr = w; pc_stall = st;
    flags_we = fwe; flags_in = fi; reg_zero = rz;
    step();
  endtask

  // Monitor: pops on every fresh bundle, checks hold and idle cycles.
  logic        stalled_q = 1'b0;
  logic        mon_on = 1'b0;
  logic [49:0] last_out = '0;
  always @(posedge clk) stalled_q = pc_stall && reset;

  always @(negedge clk) begin
    logic [49:0] cur;
    logic [48:0] e;
    cur = {ctrl_valid, UncondBr, BrTaken, BranchToReg,
           BrAddr26, CondAddr19, is_link};
    if (mon_on) begin
      checks++;
      if (stalled_q) begin
        if (cur !== last_out) begin
          errors++;
          $display("FAIL hold: got %h want %h", cur, last_out);
        end
      end else if (ctrl_valid === 1'b1) begin
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected: got %h want none", cur);
        end else begin
          e = expq.pop_front();
          if (cur[48:0] !== e) begin
            errors++;
            $display("FAIL bundle: got %h want %h", cur[48:0], e);
          end
        end
      end else if (cur !== 50'd0) begin
        errors++;
        $display("FAIL idle: got %h want 0", cur);
      end
    end
    last_out = cur;
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return {6'b000101, r[25:0]};
      1: return {6'b100101, r[25:0]};
      2: return {8'hB4, r[23:0]};
      3: return {8'h54, r[23:5], 1'b0, r[3:0]};
      4: return {11'b11010110000, r[20:0]};
      default: return r;
    endcase
  endfunction

  localparam logic [31:0] ADD = 32'h8B020020;

  initial begin
    m_flags = 4'h0;
    m_cnt = 0;
    reset = 1'b0; in_valid = 1'b0; instr = '0; pc_stall = 1'b0;
    flags_we = 1'b0; flags_in = '0; reg_zero = 1'b0;
    mon_on = 1'b1;
    // reset and non-branch
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    // B +2 then squash two
    drive(1, 1, 32'h14000002, 0, 0, 0, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    // B.EQ forwarded taken, then not taken
    drive(1, 1, 32'h54000060, 0, 1, 4'b0100, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    drive(1, 1, 32'h54000060, 0, 1, 4'b0000, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    // CBZ taken / not taken
    drive(1, 1, 32'hB4000081, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    drive(1, 1, 32'hB4000081, 0, 0, 0, 0);
    // BR X30 then BL
    drive(1, 1, 32'hD61F03C0, 0, 0, 0, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    drive(1, 1, 32'h94000010, 0, 0, 0, 0);
    // stall mid-squash, then reset abandons the squash
    drive(1, 1, ADD, 1, 0, 0, 0);
    drive(1, 1, ADD, 1, 0, 0, 0);
    drive(1, 1, ADD, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, ADD, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 9) < 8),
            rand_instr(),
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 9) < 3),
            4'($urandom),
            1'($urandom));
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Consumes the fetched LEGv8 instruction stream and produces the branch-control bundle the program counter block consumes: UncondBr, BrTaken, BranchToReg, BrAddr26 and CondAddr19. It sits between the instruction fetch queue and the PC. It holds the architectural NZCV flag register, resolves B, BL, B.cond, CBZ and BR, and squashes a fixed number of wrong-path instructions after every taken branch.

## Interface
- FLUSH_DEPTH, default 2: number of accepted instructions discarded after a taken branch (0..7).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- instr  in  32  instruction word from the fetch queue
- in_valid  in  1  instr is valid
- in_ready  out  1  unit accepts instr this cycle
- pc_stall  in  1  PC not updating; hold all outputs, accept nothing
- flags_we  in  1  ALU writes flags this cycle
- flags_in  in  4  NZCV from the ALU, bit 3 = N
- reg_zero  in  1  CBZ operand register equals zero; valid in the accept cycle
- ctrl_valid  out  1  branch-control bundle valid for one PC update
- UncondBr  out  1  selects BrAddr26 over CondAddr19
- BrTaken  out  1  take the branch path
- BranchToReg  out  1  branch target comes from the register
- BrAddr26  out  26  imm26 of B/BL
- CondAddr19  out  19  imm19 of B.cond/CBZ
- is_link  out  1  resolved instruction is BL
- flags  out  4  current NZCV register

## Operation
- Accept occurs when in_valid && in_ready. in_ready = !pc_stall, independent of state.
- Decode uses the following fields:
  - B: [31:26]=000101.
  - BL: [31:26]=100101.
  - CBZ: [31:24]=10110100.
  - B.cond: [31:24]=01010100, with cond=[3:0].
  - BR: [31:21]=11010110000.
  - Anything else is a non-branch.
- Output bundle per accepted instruction in RUN:
  - B/BL: UncondBr=1, BrTaken=1, BranchToReg=0, BrAddr26=instr[25:0], CondAddr19=0. is_link=1 only for BL.
  - B.cond: UncondBr=0, BrTaken=cond_true, CondAddr19=instr[23:5], BrAddr26=0.
  - CBZ: UncondBr=0, BrTaken=reg_zero, CondAddr19=instr[23:5].
  - BR: BrTaken=1, BranchToReg=1, UncondBr=0, both address fields 0.
  - Non-branch: all control outputs 0, ctrl_valid=1.
- cond_true is evaluated on the effective flags:
  - Effective flags are flags_in when flags_we is 1 in the accept cycle (forwarding), otherwise the flags register.
  - Conditions: EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE !(!Z&(N==V)), AL/NV (0xE/0xF) 1.
- Flags register: loads flags_in on every cycle with flags_we=1, regardless of state, stall or accept.
- State machine:
  - RUN: a taken branch (BrTaken=1) loads squash_cnt=FLUSH_DEPTH. If FLUSH_DEPTH>0, the next state is SQUASH.
  - SQUASH: each accept discards the instruction (ctrl_valid=0, no decode effect) and decrements squash_cnt. The accept that brings squash_cnt to 0 returns the unit to RUN.
  - SQUASH with pc_stall=1: no change.
- Reset (reset=0): state RUN, squash_cnt=0, flags=0000. All outputs 0 (ctrl_valid=0, all bundle fields 0, is_link=0). This applies mid-SQUASH too; the pending squash is abandoned.

## Timing
- All outputs are registered. The bundle for an instruction accepted at edge N is visible after edge N, with ctrl_valid high for exactly one cycle unless pc_stall is 1.
- While pc_stall=1, ctrl_valid and the bundle hold their last values, and the PC is assumed to ignore them.
- When no accept occurs (in_valid=0, no stall), ctrl_valid=0 next cycle. The bundle fields go to 0.
- Back-to-back accepts give one bundle per cycle, with no bubbles in RUN.
- A taken branch at edge N means the accepts at edges N+1..N+FLUSH_DEPTH are squashed. The first non-squashed bundle comes from accept FLUSH_DEPTH+1 after the branch.
- Flag forwarding is zero-cycle: flags_we and B.cond in the same cycle use flags_in. Flags become visible on `flags` one cycle after flags_we.

## Test plan
- **Reset and non-branch.** Hold reset=0 for 2 cycles: all outputs 0, flags=0000. Release, then accept 0x8B020020: next cycle ctrl_valid=1 and all control bits 0.
- **B +2 then squash (FLUSH_DEPTH=2).** Accept 0x14000002: next cycle UncondBr=1, BrTaken=1, BrAddr26=2. The next two accepted words yield ctrl_valid=0; the third (0x8B020020) yields ctrl_valid=1.
- **B.EQ with forwarding.** Flags register=0000. Accept 0x54000060 with flags_we=1, flags_in=0100 in the same cycle: BrTaken=1, CondAddr19=3. Repeat with flags_in=0000: BrTaken=0 and no squash.
- **CBZ.** Accept 0xB4000081 with reg_zero=1: BrTaken=1, UncondBr=0, CondAddr19=4. With reg_zero=0: BrTaken=0.
- **BR X30 and BL.** Accept 0xD61F03C0: BrTaken=1, BranchToReg=1, UncondBr=0. Accept 0x94000010: is_link=1, BrAddr26=16.
- **Stall and mid-squash reset.** Hold pc_stall=1 for 3 cycles during SQUASH: in_ready=0, outputs held, squash_cnt unchanged. Then assert reset=0 for 1 cycle: state returns to RUN, and the next accepted word produces ctrl_valid=1.
